// File: rtl/neuron_train_sequencer.sv
// Training-epoch sequencer for one learning neuron: fetch sample, load dendrites,
// let the forward path settle, run backprop, then issue a single weight-commit strobe.
module neuron_train_sequencer #(
  parameter int N_INPUTS      = 32,
  parameter int ADDR_W        = 8,
  parameter int EPOCH_W       = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   num_samples,
  input  logic [EPOCH_W-1:0]  num_epochs,
  input  logic [N_INPUTS-1:0] enable_mask,
  output logic                sample_req,
  output logic [ADDR_W-1:0]   sample_addr,
  input  logic                sample_valid,
  output logic                fwd_load,
  output logic                bp_req,
  input  logic                bp_ack,
  output logic                upd_strobe,
  output logic [N_INPUTS-1:0] ln_enabled,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ADDR_W-1:0]   sample_cnt,
  output logic [EPOCH_W-1:0]  epoch_cnt
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETTLE,
    BACKPROP,
    COMMIT,
    ADVANCE,
    FINISH
  } state_t;

  state_t               state;
  logic [ADDR_W-1:0]    num_samples_q;
  logic [EPOCH_W-1:0]   num_epochs_q;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [ADDR_W-1:0]    last_addr;
  logic [EPOCH_W-1:0]   epoch_next;

  assign last_addr  = num_samples_q - ADDR_W'(1);
  assign epoch_next = epoch_cnt + EPOCH_W'(1);
  assign sample_cnt = sample_addr;

  // Pulse outputs default low each cycle; abort overrides every other transition.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      num_samples_q <= '0;
      num_epochs_q  <= '0;
      settle_cnt    <= '0;
      sample_req    <= 1'b0;
      sample_addr   <= '0;
      fwd_load      <= 1'b0;
      bp_req        <= 1'b0;
      upd_strobe    <= 1'b0;
      ln_enabled    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      epoch_cnt     <= '0;
    end else begin
      done       <= 1'b0;
      aborted    <= 1'b0;
      fwd_load   <= 1'b0;
      upd_strobe <= 1'b0;
      if (state != IDLE && abort) begin
        state      <= IDLE;
        aborted    <= 1'b1;
        sample_req <= 1'b0;
        bp_req     <= 1'b0;
        busy       <= 1'b0;
        settle_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (num_samples != '0 && num_epochs != '0) begin
                num_samples_q <= num_samples;
                num_epochs_q  <= num_epochs;
                ln_enabled    <= enable_mask;
                sample_addr   <= '0;
                epoch_cnt     <= '0;
                sample_req    <= 1'b1;
                busy          <= 1'b1;
                state         <= FETCH;
              end else begin
                done <= 1'b1;
              end
            end
          end
          FETCH: begin
            if (sample_valid) begin
              sample_req <= 1'b0;
              fwd_load   <= 1'b1;
              settle_cnt <= SETTLE_W'(1);
              state      <= SETTLE;
            end
          end
          // The fwd_load cycle is the first of the settle window.
          SETTLE: begin
            if (settle_cnt == SETTLE_W'(SETTLE_CYCLES)) begin
              bp_req <= 1'b1;
              state  <= BACKPROP;
            end else begin
              settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
          end
          BACKPROP: begin
            if (bp_ack) begin
              bp_req     <= 1'b0;
              upd_strobe <= 1'b1;
              state      <= COMMIT;
            end
          end
          COMMIT: begin
            state <= ADVANCE;
          end
          ADVANCE: begin
            if (sample_addr == last_addr) begin
              sample_addr <= '0;
              epoch_cnt   <= epoch_next;
              if (epoch_next == num_epochs_q) begin
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                sample_req <= 1'b1;
                state      <= FETCH;
              end
            end else begin
              sample_addr <= sample_addr + ADDR_W'(1);
              sample_req  <= 1'b1;
              state       <= FETCH;
            end
          end
          FINISH: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// Scoreboard bench for neuron_train_sequencer: directed runs push expected
// strobe/done/aborted events; a negedge monitor pops and compares them.
module tb_neuron_train_sequencer;

  localparam int N_INPUTS = 32;
  localparam int ADDR_W   = 8;
  localparam int EPOCH_W  = 16;

  localparam int EV_STROBE = 0;
  localparam int EV_DONE   = 1;
  localparam int EV_ABORT  = 2;

  logic                clock;
  logic                reset;
  logic                start;
  logic                abort;
  logic [ADDR_W-1:0]   num_samples;
  logic [EPOCH_W-1:0]  num_epochs;
  logic [N_INPUTS-1:0] enable_mask;
  logic                sample_req;
  logic [ADDR_W-1:0]   sample_addr;
  logic                sample_valid;
  logic                fwd_load;
  logic                bp_req;
  logic                bp_ack;
  logic                upd_strobe;
  logic [N_INPUTS-1:0] ln_enabled;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [ADDR_W-1:0]   sample_cnt;
  logic [EPOCH_W-1:0]  epoch_cnt;

  neuron_train_sequencer #(
    .N_INPUTS(N_INPUTS),
    .ADDR_W(ADDR_W),
    .EPOCH_W(EPOCH_W),
    .SETTLE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .num_samples(num_samples),
    .num_epochs(num_epochs),
    .enable_mask(enable_mask),
    .sample_req(sample_req),
    .sample_addr(sample_addr),
    .sample_valid(sample_valid),
    .fwd_load(fwd_load),
    .bp_req(bp_req),
    .bp_ack(bp_ack),
    .upd_strobe(upd_strobe),
    .ln_enabled(ln_enabled),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .sample_cnt(sample_cnt),
    .epoch_cnt(epoch_cnt)
  );

  typedef struct {
    int kind;
    int addr;
    int epoch;
    bit pos;
  } ev_t;

  ev_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  int slow_addr  = -1;
  int slow_delay = 0;

  int k_end, fwd_cnt, busy_seen, req_seen, unstable, mask_bad, overlap;
  int abort_at, aborted_at;
  int req_cyc[4];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic expect_ev(input int kind, input int addr, input int epoch, input bit pos);
    ev_t e;
    e = '{kind: kind, addr: addr, epoch: epoch, pos: pos};
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      check_output("sb_unexpected_event", kind, -1);
    end else begin
      e = sb.pop_front();
      check_output("sb_kind", kind, e.kind);
      if (e.pos) begin
        check_output("sb_addr", int'(sample_addr), e.addr);
        check_output("sb_epoch", int'(epoch_cnt), e.epoch);
      end
    end
  endtask

  // Monitor: every visible strobe/done/aborted pulse must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (upd_strobe) pop_cmp(EV_STROBE);
        if (done)       pop_cmp(EV_DONE);
        if (aborted)    pop_cmp(EV_ABORT);
      end
    end
  end

  // Sample memory: valid after slow_delay cycles for slow_addr, else in the first request cycle.
  initial begin
    int wait_cnt;
    int need;
    sample_valid = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clock);
      if (sample_req && !reset) begin
        need = (int'(sample_addr) == slow_addr) ? slow_delay : 0;
        if (wait_cnt >= need) sample_valid = 1'b1;
        else begin
          sample_valid = 1'b0;
          wait_cnt++;
        end
      end else begin
        sample_valid = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Backprop engine answers in the first request cycle.
  initial begin
    bp_ack = 1'b0;
    forever begin
      @(negedge clock);
      bp_ack = bp_req && !reset;
    end
  end

  task automatic begin_run(input int ns, input int ne, input logic [N_INPUTS-1:0] mask);
    @(negedge clock);
    num_samples = ADDR_W'(ns);
    num_epochs  = EPOCH_W'(ne);
    enable_mask = mask;
    start       = 1'b1;
  endtask

  task automatic run_loop(input logic [N_INPUTS-1:0] mask, input logic [N_INPUTS-1:0] mask_mid,
                          input bit abort_en, input int limit);
    logic prev_req;
    logic [ADDR_W-1:0] prev_addr;
    k_end = -1; fwd_cnt = 0; busy_seen = 0; req_seen = 0; unstable = 0;
    mask_bad = 0; overlap = 0; abort_at = -1; aborted_at = -1;
    for (int i = 0; i < 4; i++) req_cyc[i] = 0;
    prev_req = 1'b0;
    prev_addr = '0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      enable_mask = mask_mid;
      if (sample_req) begin
        req_seen++;
        if (int'(sample_addr) < 4) req_cyc[sample_addr[1:0]]++;
        if (prev_req && sample_addr != prev_addr) unstable++;
      end
      prev_req = sample_req;
      prev_addr = sample_addr;
      if (fwd_load) fwd_cnt++;
      if (fwd_load && sample_req) overlap++;
      if (busy) busy_seen++;
      if (busy && ln_enabled != mask) mask_bad++;
      if (aborted) begin
        aborted_at = k;
        k_end = k;
        break;
      end
      if (done) begin
        k_end = k;
        break;
      end
      if (abort_en && abort_at < 0 && bp_req && sample_addr == 2 && epoch_cnt == 0) begin
        abort = 1'b1;
        abort_at = k;
      end
    end
    if (k_end < 0) check_output("run_timeout", k_end, limit);
  endtask

  task automatic apply_stimulus(input int ns, input int ne, input logic [N_INPUTS-1:0] mask,
                                input logic [N_INPUTS-1:0] mask_mid, input bit abort_en, input int limit);
    begin_run(ns, ne, mask);
    run_loop(mask, mask_mid, abort_en, limit);
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_ctl"}, {sample_req, fwd_load, bp_req, upd_strobe, busy, done, aborted}, 0);
    check_output({name, "_addr"}, sample_addr, 0);
    check_output({name, "_cnt"}, sample_cnt, 0);
    check_output({name, "_epoch"}, epoch_cnt, 0);
    check_output({name, "_ln_en"}, ln_enabled, 0);
  endtask

  initial begin
    int found;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    num_samples = '0;
    num_epochs = '0;
    enable_mask = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("post_reset");

    // Full run, zero-wait memory/backprop, mask changed mid-run.
    for (int e = 0; e < 2; e++)
      for (int a = 0; a < 3; a++) expect_ev(EV_STROBE, a, e, 1'b1);
    expect_ev(EV_DONE, 0, 2, 1'b1);
    apply_stimulus(3, 2, 32'h0000_00FF, 32'hFFFF_0000, 1'b0, 200);
    check_output("t1_latency", k_end, 49);
    check_output("t1_fwd_loads", fwd_cnt, 6);
    check_output("t1_mask_held", mask_bad, 0);
    check_output("t1_epoch_cnt", epoch_cnt, 2);
    @(negedge clock);
    check_output("t1_busy_after", busy, 0);
    check_output("t1_ln_enabled", ln_enabled, 32'h0000_00FF);
    check_output("t1_epoch_hold", epoch_cnt, 2);

    // Slow memory on address 1: request held 6 cycles with a stable address.
    slow_addr = 1;
    slow_delay = 5;
    for (int a = 0; a < 3; a++) expect_ev(EV_STROBE, a, 0, 1'b1);
    expect_ev(EV_DONE, 0, 1, 1'b1);
    apply_stimulus(3, 1, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 200);
    slow_addr = -1;
    check_output("t2_latency", k_end, 30);
    check_output("t2_req_addr1", req_cyc[1], 6);
    check_output("t2_req_addr0", req_cyc[0], 1);
    check_output("t2_addr_stable", unstable, 0);
    check_output("t2_fwd_during_req", overlap, 0);
    check_output("t2_fwd_loads", fwd_cnt, 3);

    // Abort during backprop of sample 2, epoch 0.
    expect_ev(EV_STROBE, 0, 0, 1'b1);
    expect_ev(EV_STROBE, 1, 0, 1'b1);
    expect_ev(EV_ABORT, 0, 0, 1'b0);
    apply_stimulus(3, 2, 32'h0000_00FF, 32'h0000_00FF, 1'b1, 200);
    check_output("t3_abort_issued", abort_at, 22);
    check_output("t3_aborted_pulse", aborted_at, 23);
    check_output("t3_busy", busy, 0);
    repeat (12) @(negedge clock);
    check_output("t3_idle_outputs", {sample_req, bp_req, upd_strobe, busy, done}, 0);

    // Degenerate starts: zero samples, then zero epochs.
    expect_ev(EV_DONE, 0, 0, 1'b0);
    apply_stimulus(0, 2, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 20);
    check_output("t4_done_latency", k_end, 1);
    check_output("t4_busy_seen", busy_seen, 0);
    check_output("t4_req_seen", req_seen, 0);
    expect_ev(EV_DONE, 0, 0, 1'b0);
    apply_stimulus(3, 0, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 20);
    check_output("t4b_done_latency", k_end, 1);
    check_output("t4b_busy_seen", busy_seen, 0);

    // Reset in the middle of sample 1's settle window, then a clean run.
    expect_ev(EV_STROBE, 0, 0, 1'b1);
    begin_run(3, 1, 32'h0000_00FF);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (fwd_load) found++;
      if (found == 2) break;
    end
    check_output("t5_reach_settle", found, 2);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_all_zero("t5_async_reset");
    @(negedge clock);
    reset = 1'b0;
    expect_ev(EV_STROBE, 0, 0, 1'b1);
    expect_ev(EV_STROBE, 1, 0, 1'b1);
    expect_ev(EV_DONE, 0, 1, 1'b1);
    apply_stimulus(2, 1, 32'hA5A5_0F0F, 32'h1234_5678, 1'b0, 200);
    check_output("t5_latency", k_end, 17);
    check_output("t5_mask_held", mask_bad, 0);

    repeat (4) @(negedge clock);
    check_output("sb_drained", sb.size(), 0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
